// File: rtl/multiport_register_file.sv
// Multiport register file with per-register busy scoreboard and write-back bypass.
// Latency: reads and rbusy combinational (0 cycles), writes and busy updates 1 cycle; no backpressure.
module multiport_register_file #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic              flush,
    output logic [CW-1:0]     busy_count
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_busy_count;
    logic [NREGS-1:0] w_busy_nxt;
    logic [CW-1:0]    w_busy_cnt_nxt;

    // An address names real, writable state: in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        w_busy_nxt = r_busy;
        if (we && addr_ok(waddr))
            w_busy_nxt[waddr] = 1'b0;
        // Set is applied after the clear so a coincident issue keeps the register busy.
        if (sb_set && addr_ok(sb_addr))
            w_busy_nxt[sb_addr] = 1'b1;
        if (flush)
            w_busy_nxt = '0;
    end

    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            w_busy_cnt_nxt = w_busy_cnt_nxt + CW'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (we && addr_ok(waddr))
                r_regs[waddr] <= wdata;
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_busy_cnt_nxt;
        end
    end

    assign busy_count = r_busy_count;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_ok;
        logic          w_hit;

        assign w_ra  = raddr[p*AW +: AW];
        assign w_ok  = addr_ok(w_ra) && !rst;
        // A same-cycle write-back both forwards its data and resolves the hazard.
        assign w_hit = we && (waddr == w_ra);
        assign rdata[p*XLEN +: XLEN] = !w_ok ? '0 : (w_hit ? wdata : r_regs[w_ra]);
        assign rbusy[p] = w_ok && r_busy[w_ra] && !w_hit;
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomized and directed bench for multiport_register_file against an array-based reference model.
module tb_multiport_register_file;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [XLEN-1:0]      wdata;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic                 sb_set;
    logic [AW-1:0]        sb_addr;
    logic                 flush;
    logic [CW-1:0]        busy_count;

    multiport_register_file #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Register 0 is constant zero; a write-back in flight is visible immediately.
    function automatic logic [XLEN-1:0] exp_rd(input int a);
        if (rst || a == 0) return '0;
        if (we && int'(waddr) == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (rst || a == 0) return 1'b0;
        if (we && int'(waddr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NRD; p++) begin
            int a = int'(raddr[p*AW +: AW]);
            check({tag, "_rdata"}, 64'(rdata[p*XLEN +: XLEN]), 64'(exp_rd(a)));
            check({tag, "_rbusy"}, 64'(rbusy[p]), 64'(exp_busy(a)));
        end
        check({tag, "_cnt"}, 64'(busy_count), 64'(exp_cnt()));
    endtask

    // One rising edge: the model applies the rules using the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (we) m_busy[waddr] = 1'b0;
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
            if (flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        we = 0; waddr = '0; wdata = '0; sb_set = 0; sb_addr = '0; flush = 0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr[0*AW +: AW] = AW'(a0);
        raddr[1*AW +: AW] = AW'(a1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        raddr = '0;
        model_clear();
        #2;
        set_rd(5, 7);
        #1 check_outputs("in_reset");
        tick();
        rst = 1'b0;
        #1 check_outputs("after_reset");

        // Basic write then read
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        tick();
        idle();
        set_rd(5, 0);
        #1 check("wr_rd_5", 64'(rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
        check_outputs("wr_rd");

        // Register 0 protection
        we = 1; waddr = 0; wdata = 32'h1234;
        set_rd(0, 0);
        #1 check("x0_bypass", 64'(rdata[31:0]), 64'h0);
        tick();
        idle();
        sb_set = 1; sb_addr = 0;
        tick();
        idle();
        #1 check("x0_read", 64'(rdata[31:0]), 64'h0);
        check("x0_sb_cnt", 64'(busy_count), 64'h0);

        // Bypass
        we = 1; waddr = 7; wdata = 32'h11;
        tick();
        we = 1; waddr = 7; wdata = 32'h22;
        set_rd(0, 7);
        #1 check("byp_before", 64'(rdata[63:32]), 64'h22);
        tick();
        idle();
        #1 check("byp_after", 64'(rdata[63:32]), 64'h22);

        // Scoreboard set / clear / coincident
        sb_set = 1; sb_addr = 3;
        set_rd(3, 3);
        tick();
        idle();
        #1 check("sb_cnt1", 64'(busy_count), 64'd1);
        check("sb_rbusy1", 64'(rbusy[0]), 64'd1);
        we = 1; waddr = 3; wdata = 32'hABCD;
        #1 check("sb_resolve", 64'(rbusy[0]), 64'd0);
        tick();
        idle();
        #1 check("sb_cnt0", 64'(busy_count), 64'd0);
        sb_set = 1; sb_addr = 3; we = 1; waddr = 3; wdata = 32'h5555;
        tick();
        idle();
        #1 check("sb_coinc_busy", 64'(rbusy[0]), 64'd1);
        check("sb_coinc_data", 64'(rdata[31:0]), 64'h5555);
        check_outputs("sb");

        // Flush
        we = 1; waddr = 3;
        tick();
        idle();
        foreach (m_regs[i]) if (0) ;
        sb_set = 1; sb_addr = 1; tick();
        sb_addr = 2; tick();
        sb_addr = 9; tick();
        idle();
        #1 check("fl_cnt3", 64'(busy_count), 64'd3);
        flush = 1; sb_set = 1; sb_addr = 4;
        tick();
        idle();
        #1 check("fl_cnt0", 64'(busy_count), 64'd0);
        set_rd(1, 2);
        #1 check("fl_rbusy_1_2", 64'(rbusy), 64'd0);
        set_rd(9, 4);
        #1 check("fl_rbusy_9_4", 64'(rbusy), 64'd0);

        // Async reset between edges
        for (int i = 1; i < NREGS; i++) begin
            we = 1; waddr = AW'(i); wdata = $urandom;
            sb_set = (i % 5 == 0); sb_addr = AW'(i);
            tick();
        end
        idle();
        set_rd(10, 15);
        #1 check_outputs("pre_arst");
        #2 rst = 1'b1;
        model_clear();
        #1 check("arst_rdata", 64'(rdata), 64'h0);
        check("arst_rbusy", 64'(rbusy), 64'h0);
        check("arst_cnt", 64'(busy_count), 64'h0);
        tick();
        rst = 1'b0;
        #1 check_outputs("post_arst");

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 600; n++) begin
            we      = ($urandom_range(0, 99) < 50);
            waddr   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wdata   = $urandom;
            sb_set  = ($urandom_range(0, 99) < 45);
            sb_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            flush   = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 15)
                set_rd(int'(waddr), int'(sb_addr));
            else
                set_rd($urandom_range(0, 7), $urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_clear();
            end else begin
                rst = 1'b0;
            end
            #1 check_outputs("rnd");
            tick();
        end
        rst = 1'b0;
        idle();

        // Final sweep of the whole file
        for (int i = 0; i < NREGS; i += 2) begin
            set_rd(i, i + 1);
            #1 check_outputs("sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2: number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads 0, ignores writes and is never busy.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 we  input  1  write-back enable.
REQ-008 waddr  input  AW  write-back destination register.
REQ-009 wdata  input  XLEN  write-back data.
REQ-010 raddr  input  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-011 rdata  output  NRD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
REQ-012 rbusy  output  NRD  per-port flag: the addressed register awaits a pending write-back.
REQ-013 sb_set  input  1  issue strobe: marks sb_addr busy (new producer in flight).
REQ-014 sb_addr  input  AW  register marked busy by sb_set.
REQ-015 flush  input  1  clears all busy bits (pipeline flush).
REQ-016 busy_count  output  clog2(NREGS+1)  number of registers currently busy.

Function
REQ-017 Write: at rising edge with we=1, regs[waddr] <= wdata; 1-cycle write latency.
REQ-018 Writes with waddr >= NREGS, or waddr=0 when ZERO_REG=1, have no effect on regs.
REQ-019 Read: rdata port i is combinational from raddr port i; zero-cycle read latency.
REQ-020 Bypass: when we=1 and waddr equals raddr port i (valid, nonzero when ZERO_REG=1), port i returns wdata in the same cycle.
REQ-021 Reads of raddr >= NREGS, or of register 0 when ZERO_REG=1, return 0 and rbusy=0.
REQ-022 All NRD ports are independent; identical addresses on several ports return identical data.
REQ-023 Scoreboard: one busy bit per register, all 0 after reset.
REQ-024 Rising edge with we=1 clears busy[waddr]; rising edge with sb_set=1 sets busy[sb_addr].
REQ-025 Same-edge sb_set and we on the same address: set wins; busy ends at 1 and the data write still occurs.
REQ-026 flush=1 at a rising edge clears every busy bit; it overrides a coincident sb_set, but register writes proceed normally.
REQ-027 sb_set to register 0 (ZERO_REG=1) or to an address >= NREGS is ignored.
REQ-028 rbusy port i = busy[raddr i] AND NOT (we=1 AND waddr = raddr i): a same-cycle write-back resolves the hazard.
REQ-029 busy_count is a registered population count of the busy bits.
REQ-030 busy_count updates on the same edge as the busy bits and never exceeds NREGS (or NREGS-1 when ZERO_REG=1).

Reset
REQ-031 rst=1 asynchronously clears every register to 0, every busy bit to 0, and busy_count to 0.
REQ-032 While rst=1, all writes, sb_set and flush are ignored.
REQ-033 While rst=1, every rdata port reads 0 and every rbusy bit reads 0.
REQ-034 Reset asserted mid-operation discards pending busy state; the first edge after deassertion behaves as a normal edge.

Verification
REQ-035 Write and read: we=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr0=5 -> rdata0=0xDEADBEEF.
REQ-036 x0 protection: we=1, waddr=0, wdata=0x1234; raddr0=0 -> rdata0=0; sb_set to addr 0 -> busy_count unchanged.
REQ-037 Bypass: regs[7]=0x11; same cycle drive we=1, waddr=7, wdata=0x22, raddr1=7 -> rdata1=0x22 before the edge, 0x22 after it.
REQ-038 Scoreboard:
- sb_set addr 3 -> busy_count=1, rbusy0=1 for raddr0=3.
- Then we addr 3 -> rbusy0=0 during that cycle; busy_count=0 after the edge.
- Coincident sb_set and we on addr 3 -> busy stays 1.
REQ-039 Flush: set busy on addresses 1, 2 and 9 -> busy_count=3; flush=1 together with sb_set addr 4 -> busy_count=0 and rbusy=0 for all four addresses.
REQ-040 Async reset: load regs 1-31 and set several busy bits; pulse rst between clock edges -> all rdata=0, rbusy=0 and busy_count=0 immediately, without waiting for a clock edge.
